// File: rtl/eab_mem_seq_if.sv
// EAB select / memory port bundle between the address sequencer and the datapath.
interface eab_mem_seq_if;
    logic        sel_eab1;
    logic [1:0]  sel_eab2;
    logic [15:0] eab_out;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    // The sequencer drives selects and the request; the datapath returns sum and data.
    modport master (
        output sel_eab1, sel_eab2, mem_addr, mem_wdata, mem_req, mem_we,
        input  eab_out, mem_rdata, mem_ready
    );

    modport slave (
        input  sel_eab1, sel_eab2, mem_addr, mem_wdata, mem_req, mem_we,
        output eab_out, mem_rdata, mem_ready
    );
endinterface

// File: rtl/eab_mem_seq.sv
// LC-3 address-generating instruction sequencer: LD/LDR/LDI/LEA/ST/STR/STI.
// Programs the EAB selects, captures the effective address, performs one or two
// memory accesses, and returns the write-back value with condition codes.
module eab_mem_seq (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    opcode,
    input  logic [15:0]   sr_data,
    eab_mem_seq_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          ld_reg,
    output logic [15:0]   reg_wdata,
    output logic [2:0]    cc_nzp,
    output logic          illegal
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EA   = 3'd1,
        S_MEM1 = 3'd2,
        S_MEM2 = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [3:0] OP_LEA = 4'b1110;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic [2:0]  cc_q, cc_d;
    logic        illegal_q, illegal_d;

    // Decoded properties of the latched opcode.
    // Bit 0 separates stores from loads; bits 3:2 pick direct/base/indirect.
    logic op_store, op_base, op_indirect;
    assign op_store    = op_q[0];
    assign op_base     = (op_q[3:2] == 2'b01);
    assign op_indirect = (op_q[3:2] == 2'b10);

    // Every supported opcode has bit 1 set; 1111 (TRAP) shares that pattern.
    function automatic logic is_legal(input logic [3:0] op);
        return op[1] && (op != 4'b1111);
    endfunction

    function automatic logic [2:0] nzp(input logic [15:0] v);
        return {v[15], (v == 16'h0000), (~v[15] && (v != 16'h0000))};
    endfunction

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        reg_wdata_d = reg_wdata_q;
        cc_d        = cc_q;
        illegal_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_legal(opcode)) begin
                        op_d    = opcode;
                        wdata_d = sr_data;
                        state_d = S_EA;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EA: begin
                addr_d = bus.eab_out;
                if (op_q == OP_LEA) begin
                    reg_wdata_d = bus.eab_out;
                    cc_d        = nzp(bus.eab_out);
                    state_d     = S_FIN;
                end else begin
                    state_d = S_MEM1;
                end
            end
            S_MEM1: begin
                if (bus.mem_ready) begin
                    if (op_indirect) begin
                        // Pointer fetch: the read data is the final address.
                        addr_d  = bus.mem_rdata;
                        state_d = S_MEM2;
                    end else begin
                        if (!op_store) begin
                            reg_wdata_d = bus.mem_rdata;
                            cc_d        = nzp(bus.mem_rdata);
                        end
                        state_d = S_FIN;
                    end
                end
            end
            S_MEM2: begin
                if (bus.mem_ready) begin
                    if (!op_store) begin
                        reg_wdata_d = bus.mem_rdata;
                        cc_d        = nzp(bus.mem_rdata);
                    end
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 4'h0;
            wdata_q     <= 16'h0000;
            addr_q      <= 16'h0000;
            reg_wdata_q <= 16'h0000;
            cc_q        <= 3'b000;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            reg_wdata_q <= reg_wdata_d;
            cc_q        <= cc_d;
            illegal_q   <= illegal_d;
        end
    end

    // Outputs decoded from registered state only; no input-to-output paths.
    always_comb begin
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_FIN);
        ld_reg        = (state_q == S_FIN) && !op_store;
        reg_wdata     = reg_wdata_q;
        cc_nzp        = cc_q;
        illegal       = illegal_q;
        bus.sel_eab1  = busy && op_base;
        bus.sel_eab2  = busy ? (op_base ? 2'b01 : 2'b10) : 2'b00;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_req   = (state_q == S_MEM1) || (state_q == S_MEM2);
        // STI reads its pointer first, so only its second access writes.
        bus.mem_we    = ((state_q == S_MEM1) && op_store && !op_indirect) ||
                        ((state_q == S_MEM2) && op_store);
    end

endmodule

// File: tb/tb_eab_mem_seq.sv
// Scoreboard bench for eab_mem_seq: stimulus pushes expected accesses and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_eab_mem_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [15:0] sr_data = 16'h0000;
    logic        busy, done, ld_reg, illegal;
    logic [15:0] reg_wdata;
    logic [2:0]  cc_nzp;

    eab_mem_seq_if bus();

    eab_mem_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .sr_data   (sr_data),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .ld_reg    (ld_reg),
        .reg_wdata (reg_wdata),
        .cc_nzp    (cc_nzp),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; } acc_t;
    typedef struct { logic ld; logic [15:0] rval; logic [2:0] cc; int cyc; } done_t;

    acc_t        acc_q[$];
    done_t       done_q[$];
    logic [15:0] rd_data_tab[64];
    int          rd_wait_tab[64];
    int          rd_wr = 0;
    int          rd_rd = 0;
    int          wcnt = 0;
    int          hs_count = 0;
    int          hs_done = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        illegal_exp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: drives ready/rdata just after each edge from the response table.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rd_rd   = rd_wr;
                wcnt    = 0;
                hs_done = hs_count;
                bus.mem_ready = 1'b0;
            end else begin
                if (hs_done != hs_count) begin
                    hs_done = hs_count;
                    rd_rd   = (rd_rd + 1) % 64;
                    wcnt    = 0;
                end
                if (bus.mem_req && (rd_rd != rd_wr) && (wcnt >= rd_wait_tab[rd_rd])) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rd_data_tab[rd_rd];
                end else begin
                    bus.mem_ready = 1'b0;
                    if (bus.mem_req) wcnt++;
                end
            end
        end
    end

    // Monitor: compares every completed access and every completion against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_req && bus.mem_ready) begin
                hs_count++;
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", bus.mem_addr, 16'hFFFF);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    chk("acc_addr", bus.mem_addr, a.addr);
                    chk("acc_we", bus.mem_we, a.we);
                    if (a.we) chk("acc_wdata", bus.mem_wdata, a.wdata);
                    $display("ACC t=%0d addr=%h we=%0d wdata=%h rdata=%h",
                             cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_rdata);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {15'h0, done}, 16'h0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("ld_reg", ld_reg, d.ld);
                    chk("reg_wdata", reg_wdata, d.rval);
                    chk("cc_nzp", cc_nzp, d.cc);
                    $display("TXN done t=%0d ld_reg=%0d reg_wdata=%h cc=%b",
                             cyc, ld_reg, reg_wdata, cc_nzp);
                end
            end
            if (ld_reg && !done) chk("ld_reg_without_done", ld_reg, 1'b0);
            if (illegal && !illegal_exp) chk("unexpected_illegal", illegal, 1'b0);
        end
    end

    task automatic push_rd(input logic [15:0] d, input int w);
        rd_data_tab[rd_wr] = d;
        rd_wait_tab[rd_wr] = w;
        rd_wr = (rd_wr + 1) % 64;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && done_q.size() != 0; i++) @(negedge clk);
        if (done_q.size() != 0) begin
            chk("done_timeout", done_q.size(), 0);
            done_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run_op(
        input logic [3:0]  op, input logic [15:0] sr, input logic [15:0] eab, input int nacc,
        input logic [15:0] a1, input logic we1, input logic [15:0] rd1, input int w1,
        input logic [15:0] a2, input logic we2, input logic [15:0] rd2, input int w2,
        input int lat, input logic e_ld, input logic [15:0] e_reg, input logic [2:0] e_cc,
        input logic e_s1, input logic [1:0] e_s2, input logic inject);
        acc_t  a;
        done_t d;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_sel", {bus.sel_eab1, bus.sel_eab2}, 3'b000);
        if (nacc >= 1) begin
            a.addr = a1; a.we = we1; a.wdata = sr;
            acc_q.push_back(a);
            push_rd(rd1, w1);
        end
        if (nacc >= 2) begin
            a.addr = a2; a.we = we2; a.wdata = sr;
            acc_q.push_back(a);
            push_rd(rd2, w2);
        end
        d.ld = e_ld; d.rval = e_reg; d.cc = e_cc; d.cyc = cyc + lat;
        done_q.push_back(d);
        opcode = op; sr_data = sr; bus.eab_out = eab; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ea_busy", busy, 1'b1);
        chk("ea_sel", {bus.sel_eab1, bus.sel_eab2}, {e_s1, e_s2});
        if (inject) begin
            @(negedge clk);
            start = 1'b1; opcode = 4'b1110; sr_data = 16'hDEAD;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    task automatic run_illegal(input logic [3:0] op);
        @(negedge clk);
        illegal_exp = 1'b1;
        opcode = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_pulse", illegal, 1'b1);
        chk("illegal_busy", busy, 1'b0);
        @(negedge clk);
        chk("illegal_width", illegal, 1'b0);
        chk("illegal_busy2", busy, 1'b0);
        illegal_exp = 1'b0;
    endtask

    initial begin
        bus.eab_out = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {busy, done, ld_reg, illegal, bus.mem_req, bus.mem_we, bus.sel_eab1},
            7'b0);
        chk("rst_sel2", bus.sel_eab2, 2'b00);
        chk("rst_regs", {reg_wdata, cc_nzp, bus.mem_addr, bus.mem_wdata}, 51'h0);

        // LEA: PC-relative, no memory access, done at T+2.
        run_op(4'b1110, 16'h0000, 16'h3005, 0, 16'h0, 1'b0, 16'h0, 0, 16'h0, 1'b0, 16'h0, 0,
               2, 1'b1, 16'h3005, 3'b001, 1'b0, 2'b10, 1'b0);
        // LDR with two wait states, negative result.
        run_op(4'b0110, 16'h0000, 16'h4000, 1, 16'h4000, 1'b0, 16'h8001, 2, 16'h0, 1'b0, 16'h0, 0,
               5, 1'b1, 16'h8001, 3'b100, 1'b1, 2'b01, 1'b0);
        // STI: pointer read then write; write-back state unchanged.
        run_op(4'b1011, 16'h00AA, 16'h3010, 2, 16'h3010, 1'b0, 16'h5000, 0, 16'h5000, 1'b1, 16'h0, 0,
               4, 1'b0, 16'h8001, 3'b100, 1'b0, 2'b10, 1'b0);
        // LDI returning zero.
        run_op(4'b1010, 16'h0000, 16'h3020, 2, 16'h3020, 1'b0, 16'h6000, 0, 16'h6000, 1'b0, 16'h0000, 0,
               4, 1'b1, 16'h0000, 3'b010, 1'b0, 2'b10, 1'b0);
        // ST direct.
        run_op(4'b0011, 16'h1234, 16'h2000, 1, 16'h2000, 1'b1, 16'h0, 0, 16'h0, 1'b0, 16'h0, 0,
               3, 1'b0, 16'h0000, 3'b010, 1'b0, 2'b10, 1'b0);
        // STR with one wait state.
        run_op(4'b0111, 16'h8000, 16'h2001, 1, 16'h2001, 1'b1, 16'h0, 1, 16'h0, 1'b0, 16'h0, 0,
               4, 1'b0, 16'h0000, 3'b010, 1'b1, 2'b01, 1'b0);
        // Illegal opcodes, including TRAP which shares the bit-1 pattern.
        run_illegal(4'b0001);
        run_illegal(4'b1111);
        // LD with a start injected during MEM1: must be ignored, one done only.
        run_op(4'b0010, 16'h0BEE, 16'h3100, 1, 16'h3100, 1'b0, 16'h7FFF, 3, 16'h0, 1'b0, 16'h0, 0,
               6, 1'b1, 16'h7FFF, 3'b001, 1'b0, 2'b10, 1'b1);
        repeat (3) @(negedge clk);
        chk("ignored_start_idle", busy, 1'b0);

        // Reset during LDI MEM2 (second access stalled).
        @(negedge clk);
        begin
            acc_t a;
            a.addr = 16'h3030; a.we = 1'b0; a.wdata = 16'h4444;
            acc_q.push_back(a);
        end
        push_rd(16'h7000, 0);
        push_rd(16'h1111, 500);
        opcode = 4'b1010; sr_data = 16'h4444; bus.eab_out = 16'h3030; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (n < 10 && !(bus.mem_req && bus.mem_addr == 16'h7000)) begin
                @(negedge clk);
                n++;
            end
            chk("reach_mem2", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h7000});
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", {busy, done, ld_reg, illegal, bus.mem_req, bus.mem_we}, 6'b0);
        chk("midrst_sel", {bus.sel_eab1, bus.sel_eab2}, 3'b000);
        chk("midrst_wb", {reg_wdata, cc_nzp}, 19'h0);
        chk("midrst_bus", {bus.mem_addr, bus.mem_wdata}, 32'h0);
        reset = 1'b0;
        chk("midrst_acc_left", acc_q.size(), 0);
        @(negedge clk);
        chk("postrst_done", done, 1'b0);

        // LD after reset completes normally.
        run_op(4'b0010, 16'h0000, 16'h0042, 1, 16'h0042, 1'b0, 16'h0055, 0, 16'h0, 1'b0, 16'h0, 0,
               3, 1'b1, 16'h0055, 3'b001, 1'b0, 2'b10, 1'b0);

        repeat (2) @(negedge clk);
        chk("acc_q_empty", acc_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eab_mem_seq.md
# eab_mem_seq

Sequencer that drives the effective-address block and the memory port for LC-3 address-generating instructions: LD, LDR, LDI, LEA, ST, STR and STI. On `start` it latches the opcode and programs the EAB select lines. It then captures the computed address and performs one or two memory accesses through a req/ready handshake. Finally it returns load/LEA results for register write-back together with the condition codes. It sits between the control unit and the EAB/memory interface.

## Interface
- No parameters. Data width is fixed at 16, opcode width at 4.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin an operation. Sampled only in IDLE.
- `opcode` in 4: IR[15:12]. Sampled with `start`.
- `sr_data` in 16: store data. Sampled with `start`.
- `sel_eab1` out 1: EAB base select. 1 = register base, 0 = PC.
- `sel_eab2` out 2: EAB offset select. 01 = offset6, 10 = offset9.
- `eab_out` in 16: EAB sum.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_req` out 1: access request.
- `mem_we` out 1: 1 = write.
- `mem_rdata` in 16: read data. Valid when `mem_req && mem_ready`.
- `mem_ready` in 1: access complete this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `ld_reg` out 1: one-cycle register write-enable pulse. Coincident with `done` for LD/LDR/LDI/LEA.
- `reg_wdata` out 16: write-back value. Held until the next write-back.
- `cc_nzp` out 3: {n,z,p} of the last write-back value.
- `illegal` out 1: one-cycle pulse when `start` arrives with an unsupported opcode.

## Operation
- **Opcode decode**
  - LD 0010, LDR 0110, LDI 1010, LEA 1110: loads.
  - ST 0011, STR 0111, STI 1011: stores.
  - Any other opcode is illegal.
- **EAB select decode** (driven from the latched opcode while busy; 0/00 in IDLE)
  - LDR/STR: `sel_eab1`=1, `sel_eab2`=01.
  - All others: `sel_eab1`=0, `sel_eab2`=10.
- **States:** IDLE, EA, MEM1, MEM2, FIN.
- **IDLE**
  - `start` with a legal opcode: latch opcode and `sr_data`, go to EA.
  - `start` with an illegal opcode: pulse `illegal`, stay in IDLE.
- **EA**
  - Register `eab_out` into `mem_addr`.
  - LEA: set `reg_wdata`=`eab_out`, go to FIN.
  - All other opcodes: go to MEM1.
- **MEM1**
  - Assert `mem_req`.
  - `mem_we`=1 for ST/STR, 0 for LD/LDR/LDI/STI.
  - `mem_wdata`=latched `sr_data`.
  - On `mem_ready`:
    - LD/LDR: set `reg_wdata`=`mem_rdata`, go to FIN.
    - ST/STR: go to FIN.
    - LDI/STI: set `mem_addr`=`mem_rdata`, go to MEM2.
- **MEM2**
  - Assert `mem_req`. `mem_we`=1 for STI, 0 for LDI.
  - On `mem_ready`:
    - LDI: set `reg_wdata`=`mem_rdata`, go to FIN.
    - STI: go to FIN.
- **FIN**
  - Pulse `done`.
  - For loads and LEA: pulse `ld_reg` and update `cc_nzp`.
    - n = `reg_wdata`[15].
    - z = (`reg_wdata` == 0).
    - p = otherwise.
  - Go to IDLE.
- **Handshake rules**
  - While `mem_req` is high, `mem_addr`, `mem_we` and `mem_wdata` are stable.
  - `mem_req` stays high until `mem_ready` is sampled high, then deasserts on the next edge.
  - There is no wait-state limit.
  - `mem_ready` outside a request is ignored.
- **Requester obligations:** PC, base register and IR feeding the EAB stay stable from `start` until `done`. Only the value present in EA is used.
- **Ignored start:** `start` while `busy` is ignored. No queueing.
- **Arithmetic:** no arithmetic inside the block. Address sums come from the EAB and wrap modulo 2^16 there.

## Timing
- **Reset values:** `mem_addr`, `mem_wdata`, `reg_wdata` = 0; `cc_nzp`=000; all 1-bit outputs 0; `sel_eab2`=00; state IDLE.
- **Reset mid-operation:** takes effect at the next edge. `mem_req` drops, no `done`, no `ld_reg`, and `reg_wdata`/`cc_nzp` clear.
- **Latency** (`start` sampled at edge T, `mem_ready` high on the first request cycle):
  - LEA: `done` in cycle T+2.
  - LD/LDR/ST/STR: `done` in cycle T+3.
  - LDI/STI: `done` in cycle T+4.
  - Each extra wait cycle on `mem_ready` adds one cycle.
- **Back-to-back:** the earliest next `start` is the cycle after `done` (IDLE). Throughput is therefore one operation per latency+1 cycles.
- **Illegal pulse:** `illegal` is high in the cycle after the sampling edge (T+1). `busy` stays 0.
- **Pulse widths:** `done`, `ld_reg` and `illegal` are exactly one cycle wide.
- **Combinational paths:** none from inputs to outputs; all outputs are registered or state-decoded.

## Test plan
- **LEA:** `opcode`=1110 and `eab_out`=16'h3005 → `sel_eab1`=0 and `sel_eab2`=10 in EA. At T+2: `done`=`ld_reg`=1, `reg_wdata`=16'h3005, `cc_nzp`=001.
- **LDR with wait states:** `eab_out`=16'h4000, `mem_ready` low for 2 cycles, `mem_rdata`=16'h8001 → `mem_req` high for 3 cycles with `mem_addr`=16'h4000 and `mem_we`=0. `done` at T+5, `reg_wdata`=16'h8001, `cc_nzp`=100.
- **STI:** `eab_out`=16'h3010, first read returns 16'h5000, `sr_data`=16'h00AA → first access reads 16'h3010. Second access has `mem_we`=1, `mem_addr`=16'h5000, `mem_wdata`=16'h00AA. `done` at T+4, `ld_reg`=0, `cc_nzp` unchanged.
- **LDI returning zero:** final read data 16'h0000 → `cc_nzp`=010 and `ld_reg` pulse at T+4.
- **Illegal and busy start:** `opcode`=0001 → `illegal` pulse at T+1, no `busy`. A `start` during LD MEM1 is ignored, with exactly one `done`.
- **Reset mid-operation:** `reset` during LDI MEM2 → next cycle IDLE, `mem_req`=0, all outputs at reset values, no `done`. A subsequent LD completes normally.
